// File: rtl/radio_bridge_mc.sv
// Multi-channel radio bridge: per-channel Tx/Rx sequencing through a guard interval,
// DAC gating, ADC pipelining and a shared RSSI ADC clock with capture strobe.
module radio_bridge_mc #(
    parameter int NUM_RADIOS   = 2,
    parameter int DAC_WIDTH    = 16,
    parameter int ADC_WIDTH    = 14,
    parameter int RSSI_WIDTH   = 10,
    parameter int PIPE_DEPTH   = 1,
    parameter int GUARD_CYCLES = 8,
    parameter int RSSI_DIV     = 4
) (
    input  logic                             converter_clock_in,
    input  logic                             reset,
    input  logic [NUM_RADIOS-1:0]            controller_TxEn,
    input  logic [NUM_RADIOS-1:0]            controller_RxEn,
    input  logic [6*NUM_RADIOS-1:0]          user_Tx_gain,
    input  logic [2*NUM_RADIOS-1:0]          user_RxRF_gain,
    input  logic [5*NUM_RADIOS-1:0]          user_RxBB_gain,
    input  logic [NUM_RADIOS*DAC_WIDTH-1:0]  user_DAC_I,
    input  logic [NUM_RADIOS*DAC_WIDTH-1:0]  user_DAC_Q,
    input  logic [NUM_RADIOS*ADC_WIDTH-1:0]  radio_ADC_I,
    input  logic [NUM_RADIOS*ADC_WIDTH-1:0]  radio_ADC_Q,
    input  logic [NUM_RADIOS*RSSI_WIDTH-1:0] radio_RSSI_ADC_D,
    output logic [NUM_RADIOS-1:0]            radio_TxEn,
    output logic [NUM_RADIOS-1:0]            radio_RxEn,
    output logic [7*NUM_RADIOS-1:0]          radio_B,
    output logic [NUM_RADIOS*DAC_WIDTH-1:0]  radio_DAC_I,
    output logic [NUM_RADIOS*DAC_WIDTH-1:0]  radio_DAC_Q,
    output logic [NUM_RADIOS*ADC_WIDTH-1:0]  user_ADC_I,
    output logic [NUM_RADIOS*ADC_WIDTH-1:0]  user_ADC_Q,
    output logic [NUM_RADIOS-1:0]            radio_RSSI_ADC_clk,
    output logic [NUM_RADIOS*RSSI_WIDTH-1:0] user_RSSI_ADC_D,
    output logic [NUM_RADIOS-1:0]            user_RSSI_valid,
    output logic [2*NUM_RADIOS-1:0]          user_radio_state
);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int RW = $clog2(RSSI_DIV);
    localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD_CYCLES - 1);
    localparam logic [RW-1:0] RSSI_HALF  = RW'(RSSI_DIV / 2);
    localparam logic [RW-1:0] RSSI_LAST  = RW'(RSSI_DIV - 1);

    localparam logic [1:0] ST_OFF   = 2'b00;
    localparam logic [1:0] ST_GUARD = 2'b01;
    localparam logic [1:0] ST_RX    = 2'b10;
    localparam logic [1:0] ST_TX    = 2'b11;

    localparam int AW = NUM_RADIOS * ADC_WIDTH;

    logic [NUM_RADIOS-1:0][1:0]        req;
    logic [NUM_RADIOS-1:0][1:0]        state_q, state_d;
    logic [NUM_RADIOS-1:0][GW-1:0]     gcnt_q, gcnt_d;
    logic [NUM_RADIOS-1:0]             txen_q, txen_d, rxen_q, rxen_d;
    logic [7*NUM_RADIOS-1:0]           radio_b_q, radio_b_d;
    logic [NUM_RADIOS*DAC_WIDTH-1:0]   dac_i_q, dac_i_d, dac_q_q, dac_q_d;
    logic [PIPE_DEPTH-1:0][AW-1:0]     adc_i_q, adc_i_d, adc_q_q, adc_q_d;
    logic [RW-1:0]                     rssi_cnt_q, rssi_cnt_d;
    logic                              rssi_clk_q, rssi_clk_d;
    logic                              rssi_valid_q, rssi_valid_d;
    logic [NUM_RADIOS*RSSI_WIDTH-1:0]  rssi_d_q, rssi_d_d;

    // Both enables high is illegal and maps to OFF.
    always_comb begin
        req = '0;
        for (int k = 0; k < NUM_RADIOS; k++) begin
            if (controller_TxEn[k] && !controller_RxEn[k])
                req[k] = ST_TX;
            else if (controller_RxEn[k] && !controller_TxEn[k])
                req[k] = ST_RX;
            else
                req[k] = ST_OFF;
        end
    end

    always_comb begin
        state_d   = state_q;
        gcnt_d    = gcnt_q;
        txen_d    = '0;
        rxen_d    = '0;
        radio_b_d = '0;
        dac_i_d   = '0;
        dac_q_d   = '0;
        for (int k = 0; k < NUM_RADIOS; k++) begin
            case (state_q[k])
                ST_OFF: begin
                    if (req[k] != ST_OFF) begin
                        state_d[k] = ST_GUARD;
                        gcnt_d[k]  = GUARD_INIT;
                    end
                end
                ST_GUARD: begin
                    if (gcnt_q[k] != '0)
                        gcnt_d[k] = gcnt_q[k] - 1'b1;
                    else
                        state_d[k] = req[k];
                end
                default: begin
                    if (req[k] == ST_OFF) begin
                        state_d[k] = ST_OFF;
                    end else if (req[k] != state_q[k]) begin
                        state_d[k] = ST_GUARD;
                        gcnt_d[k]  = GUARD_INIT;
                    end
                end
            endcase
            // Outputs follow the state being entered so they change with it.
            rxen_d[k] = (state_d[k] == ST_RX);
            txen_d[k] = (state_d[k] == ST_TX);
            if (state_d[k] == ST_RX)
                radio_b_d[k*7 +: 7] = {user_RxRF_gain[k*2 +: 2], user_RxBB_gain[k*5 +: 5]};
            else if (state_d[k] == ST_TX)
                radio_b_d[k*7 +: 7] = {1'b0, user_Tx_gain[k*6 +: 6]};
            if (state_d[k] == ST_TX) begin
                dac_i_d[k*DAC_WIDTH +: DAC_WIDTH] = user_DAC_I[k*DAC_WIDTH +: DAC_WIDTH];
                dac_q_d[k*DAC_WIDTH +: DAC_WIDTH] = user_DAC_Q[k*DAC_WIDTH +: DAC_WIDTH];
            end
        end
    end

    always_comb begin
        adc_i_d    = adc_i_q;
        adc_q_d    = adc_q_q;
        adc_i_d[0] = radio_ADC_I;
        adc_q_d[0] = radio_ADC_Q;
        for (int s = 1; s < PIPE_DEPTH; s++) begin
            adc_i_d[s] = adc_i_q[s-1];
            adc_q_d[s] = adc_q_q[s-1];
        end
    end

    // One shared counter keeps every channel's RSSI clock phase-aligned.
    always_comb begin
        rssi_clk_d   = (rssi_cnt_q < RSSI_HALF);
        rssi_cnt_d   = (rssi_cnt_q == RSSI_LAST) ? '0 : rssi_cnt_q + 1'b1;
        rssi_valid_d = (rssi_cnt_q == RSSI_HALF);
        rssi_d_d     = rssi_valid_d ? radio_RSSI_ADC_D : rssi_d_q;
    end

    always_ff @(posedge converter_clock_in) begin
        if (reset) begin
            state_q      <= '0;
            gcnt_q       <= '0;
            txen_q       <= '0;
            rxen_q       <= '0;
            radio_b_q    <= '0;
            dac_i_q      <= '0;
            dac_q_q      <= '0;
            adc_i_q      <= '0;
            adc_q_q      <= '0;
            rssi_cnt_q   <= '0;
            rssi_clk_q   <= 1'b0;
            rssi_valid_q <= 1'b0;
            rssi_d_q     <= '0;
        end else begin
            state_q      <= state_d;
            gcnt_q       <= gcnt_d;
            txen_q       <= txen_d;
            rxen_q       <= rxen_d;
            radio_b_q    <= radio_b_d;
            dac_i_q      <= dac_i_d;
            dac_q_q      <= dac_q_d;
            adc_i_q      <= adc_i_d;
            adc_q_q      <= adc_q_d;
            rssi_cnt_q   <= rssi_cnt_d;
            rssi_clk_q   <= rssi_clk_d;
            rssi_valid_q <= rssi_valid_d;
            rssi_d_q     <= rssi_d_d;
        end
    end

    assign radio_TxEn         = txen_q;
    assign radio_RxEn         = rxen_q;
    assign radio_B            = radio_b_q;
    assign radio_DAC_I        = dac_i_q;
    assign radio_DAC_Q        = dac_q_q;
    assign user_ADC_I         = adc_i_q[PIPE_DEPTH-1];
    assign user_ADC_Q         = adc_q_q[PIPE_DEPTH-1];
    assign radio_RSSI_ADC_clk = {NUM_RADIOS{rssi_clk_q}};
    assign user_RSSI_valid    = {NUM_RADIOS{rssi_valid_q}};
    assign user_RSSI_ADC_D    = rssi_d_q;
    assign user_radio_state   = state_q;

endmodule

// File: tb/tb_radio_bridge_mc.sv
// Directed bench for radio_bridge_mc: two channels, 8-cycle guard, RSSI_DIV=4, 3-stage ADC pipe.
module tb_radio_bridge_mc;
    localparam int N  = 2;
    localparam int DW = 16;
    localparam int AW = 14;
    localparam int RW = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      tx_en, rx_en;
    logic [6*N-1:0]    tx_gain;
    logic [2*N-1:0]    rf_gain;
    logic [5*N-1:0]    bb_gain;
    logic [N*DW-1:0]   dac_i, dac_q;
    logic [N*AW-1:0]   adc_i, adc_q;
    logic [N*RW-1:0]   rssi_in;
    logic [N-1:0]      r_txen, r_rxen, r_rssi_clk, u_rssi_valid;
    logic [7*N-1:0]    r_b;
    logic [N*DW-1:0]   r_dac_i, r_dac_q;
    logic [N*AW-1:0]   u_adc_i, u_adc_q;
    logic [N*RW-1:0]   u_rssi_d;
    logic [2*N-1:0]    u_state;

    int n_cmp = 0;
    int n_err = 0;

    radio_bridge_mc #(
        .NUM_RADIOS(N), .DAC_WIDTH(DW), .ADC_WIDTH(AW), .RSSI_WIDTH(RW),
        .PIPE_DEPTH(3), .GUARD_CYCLES(8), .RSSI_DIV(4)
    ) dut (
        .converter_clock_in(clk), .reset(reset),
        .controller_TxEn(tx_en), .controller_RxEn(rx_en),
        .user_Tx_gain(tx_gain), .user_RxRF_gain(rf_gain), .user_RxBB_gain(bb_gain),
        .user_DAC_I(dac_i), .user_DAC_Q(dac_q),
        .radio_ADC_I(adc_i), .radio_ADC_Q(adc_q), .radio_RSSI_ADC_D(rssi_in),
        .radio_TxEn(r_txen), .radio_RxEn(r_rxen), .radio_B(r_b),
        .radio_DAC_I(r_dac_i), .radio_DAC_Q(r_dac_q),
        .user_ADC_I(u_adc_i), .user_ADC_Q(u_adc_q),
        .radio_RSSI_ADC_clk(r_rssi_clk), .user_RSSI_ADC_D(u_rssi_d),
        .user_RSSI_valid(u_rssi_valid), .user_radio_state(u_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [N*RW-1:0] exp_rssi;
    logic [RW-1:0]   v0, v1;

    initial begin
        // Reset with every input driven nonzero
        reset   = 1'b1;
        tx_en   = '1;       rx_en   = 2'b01;
        tx_gain = '1;       rf_gain = '1;       bb_gain = '1;
        dac_i   = '1;       dac_q   = '1;
        adc_i   = '1;       adc_q   = '1;       rssi_in = '1;
        tick(); tick();
        chk("rst_state", u_state, 0);
        chk("rst_txen", r_txen, 0);
        chk("rst_rxen", r_rxen, 0);
        chk("rst_b", r_b, 0);
        chk("rst_dac", {r_dac_i, r_dac_q}, 0);
        chk("rst_adc", {u_adc_i, u_adc_q}, 0);
        chk("rst_rssi", {r_rssi_clk, u_rssi_valid, u_rssi_d}, 0);

        // OFF->RX on ch0 alongside RSSI clock/strobe from reset release
        tx_en = '0; rx_en = 2'b01;
        tx_gain = '0; dac_i = '0; dac_q = '0; adc_i = '0; adc_q = '0;
        rf_gain = 4'b0010; bb_gain = 10'h013;
        reset = 1'b0;
        exp_rssi = '0;
        for (int t = 1; t <= 12; t++) begin
            v0 = RW'(t * 37 + 5);
            v1 = RW'(t * 11 + 1);
            rssi_in = {v1, v0};
            tick();
            chk("rssi_clk", r_rssi_clk, (((t - 1) % 4) < 2) ? 2'b11 : 2'b00);
            chk("rssi_valid", u_rssi_valid, (((t - 1) % 4) == 2) ? 2'b11 : 2'b00);
            if (((t - 1) % 4) == 2) exp_rssi = {v1, v0};
            chk("rssi_data", u_rssi_d, exp_rssi);
            if (t <= 8) begin
                chk("rx_guard_state", u_state, 4'b0001);
                chk("rx_guard_en", r_rxen, 0);
                chk("rx_guard_b", r_b, 0);
            end else begin
                chk("rx_state", u_state, 4'b0010);
                chk("rx_en", r_rxen, 2'b01);
                chk("rx_b", r_b[6:0], 7'b1010011);
            end
        end

        // Gain change in RX appears one cycle later
        rf_gain = 4'b0001; bb_gain = 10'h005;
        chk("rx_b_hold", r_b[6:0], 7'b1010011);
        tick();
        chk("rx_b_upd", r_b[6:0], 7'b0100101);

        // Illegal request on ch1 keeps it OFF, ch0 unaffected
        tx_en = 2'b10; rx_en = 2'b11;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("both_state", u_state, 4'b0010);
            chk("both_en", {r_txen, r_rxen}, 4'b0001);
        end

        // RX->TX on ch0
        tx_en = 2'b01; rx_en = 2'b00;
        tx_gain = 12'h02A; dac_i = 32'h0000_1234; dac_q = 32'h0000_0BCD;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("sw_state", u_state, 4'b0001);
            chk("sw_en", {r_txen, r_rxen}, 0);
            chk("sw_b", r_b, 0);
            chk("sw_dac", r_dac_i, 0);
        end
        tick();
        chk("tx_state", u_state, 4'b0011);
        chk("tx_en", {r_txen, r_rxen}, 4'b0100);
        chk("tx_b", r_b, 14'h002A);
        chk("tx_dac_i", r_dac_i, 32'h0000_1234);
        chk("tx_dac_q", r_dac_q, 32'h0000_0BCD);
        dac_i = 32'hFFFF_5678; tx_gain = 12'hFD5;
        chk("tx_dac_hold", r_dac_i, 32'h0000_1234);
        tick();
        chk("tx_dac_upd", r_dac_i, 32'h0000_5678);
        chk("tx_b_upd", r_b, 14'h0015);

        // TxEn drop -> OFF at the next edge
        tx_en = 2'b00;
        tick();
        chk("drop_state", u_state, 0);
        chk("drop_en", r_txen, 0);
        chk("drop_dac", r_dac_i, 0);
        chk("drop_b", r_b, 0);

        // ADC step through the 3-stage pipe
        adc_i = {14'h1555, 14'h0AAA}; adc_q = {14'h0123, 14'h3210};
        tick(); chk("adc_d1", u_adc_i, 0);
        tick(); chk("adc_d2", u_adc_i, 0);
        tick(); chk("adc_i_d3", u_adc_i, {14'h1555, 14'h0AAA});
        chk("adc_q_d3", u_adc_q, {14'h0123, 14'h3210});

        // Reset in guard cycle 4 with request held restarts the guard
        rx_en = 2'b01;
        for (int t = 0; t < 4; t++) tick();
        chk("pre_rst_state", u_state, 4'b0001);
        reset = 1'b1;
        tick();
        chk("mid_rst_state", u_state, 0);
        chk("mid_rst_rssi", {r_rssi_clk, u_rssi_valid}, 0);
        reset = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("rg_state", u_state, 4'b0001);
            chk("rg_en", r_rxen, 0);
            if (t == 1) chk("rg_rssi_rise", r_rssi_clk, 2'b11);
        end
        tick();
        chk("rg_rx_state", u_state, 4'b0010);
        chk("rg_rx_en", r_rxen, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
